// File: rtl/disp_mux_bcd.sv
// Scanned driver for a 4-digit common-anode 7-segment display fed by three BCD digits.
// Inputs are snapshotted once per frame; the leftmost position is always dark.
module disp_mux_bcd #(
    parameter int DIGIT_DIV = 50000,
    parameter int DP_POS    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic       en,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    localparam int            CW      = $clog2(DIGIT_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGIT_DIV - 1);
    localparam int            LZ_T    = (DP_POS >= 0 && DP_POS <= 2) ? DP_POS : 0;

    typedef enum logic [1:0] {
        SLOT_D0   = 2'd0,
        SLOT_D1   = 2'd1,
        SLOT_D2   = 2'd2,
        SLOT_DARK = 2'd3
    } slot_t;

    logic [CW-1:0] div_cnt, cnt_nxt;
    slot_t         sel, sel_nxt;
    logic [11:0]   shadow, sh_nxt;
    logic [3:0]    an_nxt;
    logic [7:0]    sseg_nxt;
    logic          wrap, frame, blank1, blank2;

    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 8'hC0;
            4'd1:    seg_decode = 8'hF9;
            4'd2:    seg_decode = 8'hA4;
            4'd3:    seg_decode = 8'hB0;
            4'd4:    seg_decode = 8'h99;
            4'd5:    seg_decode = 8'h92;
            4'd6:    seg_decode = 8'h82;
            4'd7:    seg_decode = 8'hF8;
            4'd8:    seg_decode = 8'h80;
            4'd9:    seg_decode = 8'h90;
            default: seg_decode = 8'hBF;
        endcase
    endfunction

    always_comb begin
        wrap    = (div_cnt == CNT_MAX);
        frame   = wrap && (sel == SLOT_DARK);
        cnt_nxt = wrap ? '0 : div_cnt + 1'b1;
        sel_nxt = wrap ? slot_t'(sel + 2'd1) : sel;
        sh_nxt  = frame ? {d2, d1, d0} : shadow;

        // Outputs are decoded from the upcoming slot/snapshot so they switch with sel.
        blank2 = blank_lz && (LZ_T < 2) && (sh_nxt[11:8] == 4'd0);
        blank1 = blank_lz && (LZ_T < 1) && (sh_nxt[11:4] == 8'd0);

        an_nxt   = '1;
        sseg_nxt = '1;
        if (en) begin
            case (sel_nxt)
                SLOT_D0: begin
                    an_nxt   = 4'b1110;
                    sseg_nxt = seg_decode(sh_nxt[3:0]);
                    if (DP_POS == 0) sseg_nxt[7] = 1'b0;
                end
                SLOT_D1: begin
                    an_nxt = 4'b1101;
                    if (!blank1) begin
                        sseg_nxt = seg_decode(sh_nxt[7:4]);
                        if (DP_POS == 1) sseg_nxt[7] = 1'b0;
                    end
                end
                SLOT_D2: begin
                    an_nxt = 4'b1011;
                    if (!blank2) begin
                        sseg_nxt = seg_decode(sh_nxt[11:8]);
                        if (DP_POS == 2) sseg_nxt[7] = 1'b0;
                    end
                end
                default: begin
                    an_nxt   = '1;
                    sseg_nxt = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            sel        <= SLOT_D0;
            shadow     <= '0;
            an         <= '1;
            sseg       <= '1;
            frame_tick <= 1'b0;
        end else begin
            div_cnt    <= cnt_nxt;
            sel        <= sel_nxt;
            shadow     <= sh_nxt;
            an         <= an_nxt;
            sseg       <= sseg_nxt;
            frame_tick <= frame;
        end
    end

endmodule

// File: tb/tb_disp_mux_bcd.sv
// Scoreboard bench for disp_mux_bcd (DIGIT_DIV=4, DP_POS=1): expected display states are
// queued per clock edge and a negedge monitor pops and compares them.
module tb_disp_mux_bcd;

    localparam int DIV = 4;
    localparam int DP  = 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] d2 = '0, d1 = '0, d0 = '0;
    logic       en = 1'b1;
    logic       blank_lz = 1'b0;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frame_tick;

    disp_mux_bcd #(.DIGIT_DIV(DIV), .DP_POS(DP)) dut (
        .clk(clk), .reset_n(reset_n), .d2(d2), .d1(d1), .d0(d0),
        .en(en), .blank_lz(blank_lz), .an(an), .sseg(sseg), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [3:0] an;
        logic [7:0] sseg;
        logic       ft;
        string      nm;
    } exp_t;

    exp_t sb[$];
    exp_t x;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   gcyc  = 0;
    int   base  = 0;

    always @(posedge clk) gcyc <= gcyc + 1;

    // Monitor: compare every queued expectation due at this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].e <= gcyc) begin
            x = sb.pop_front();
            n_cmp++;
            if (x.e != gcyc) begin
                n_bad++;
                $display("FAIL %s: check for cycle %0d missed (now %0d), required an=%b sseg=%h ft=%b",
                         x.nm, x.e, gcyc, x.an, x.sseg, x.ft);
            end else if (an !== x.an || sseg !== x.sseg || frame_tick !== x.ft) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: got an=%b sseg=%h ft=%b, required an=%b sseg=%h ft=%b",
                         x.nm, gcyc - base, an, sseg, frame_tick, x.an, x.sseg, x.ft);
            end
        end
    end

    task automatic push(input string nm, input int e, input logic [3:0] a,
                        input logic [7:0] s, input logic ft);
        exp_t t;
        t.e = e; t.an = a; t.sseg = s; t.ft = ft; t.nm = nm;
        sb.push_back(t);
    endtask

    // Expected {an,sseg} per slot for edges e0..e1 after release; frame_tick every 16th edge.
    task automatic push_phase(input string nm, input int e0, input int e1,
                              input logic [11:0] t0, input logic [11:0] t1,
                              input logic [11:0] t2, input logic [11:0] t3);
        logic [11:0] v;
        for (int e = e0; e <= e1; e++) begin
            case ((e / 4) % 4)
                0:       v = t0;
                1:       v = t1;
                2:       v = t2;
                default: v = t3;
            endcase
            push(nm, base + e, v[11:8], v[7:0], (e % 16) == 0);
        end
    endtask

    task automatic go_to(input int e);
        while (gcyc < base + e) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) begin
            @(posedge clk); #2;
            push("reset", gcyc, 4'hF, 8'hFF, 1'b0);
        end
        @(posedge clk); #2;
        reset_n = 1'b1;
        base = gcyc;
        d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;

        push_phase("pre_frame", 1, 15,    12'hEC0, 12'hD40, 12'hBC0, 12'hFFF);
        push_phase("scan_123", 16, 63,    12'hEB0, 12'hD24, 12'hBF9, 12'hFFF);
        push_phase("snap_d0_7", 64, 79,   12'hEF8, 12'hD24, 12'hBF9, 12'hFFF);
        push_phase("lz_off", 80, 95,      12'hE92, 12'hD40, 12'hBC0, 12'hFFF);
        push_phase("lz_on", 96, 111,      12'hE92, 12'hD40, 12'hBFF, 12'hFFF);
        push_phase("dash_d0", 112, 127,   12'hEBF, 12'hD40, 12'hBFF, 12'hFFF);
        push_phase("dash_d1", 128, 145,   12'hEC0, 12'hD3F, 12'hBFF, 12'hFFF);
        push_phase("en_off", 146, 165,    12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        push_phase("en_on", 166, 166,     12'hEC0, 12'hD3F, 12'hBFF, 12'hFFF);

        go_to(20);  d0 = 4'd9;
        go_to(26);  d0 = 4'd3;
        go_to(52);  d0 = 4'd7;
        go_to(70);  d2 = 4'd0; d1 = 4'd0; d0 = 4'd5;
        go_to(95);  blank_lz = 1'b1;
        go_to(100); d0 = 4'hC;
        go_to(116); d1 = 4'hC; d0 = 4'd0;
        go_to(145); en = 1'b0;
        go_to(165); en = 1'b1;

        go_to(167);
        reset_n = 1'b0;
        blank_lz = 1'b0;
        push("rst_async", gcyc, 4'hF, 8'hFF, 1'b0);
        go_to(168); push("rst_hold", gcyc, 4'hF, 8'hFF, 1'b0);
        go_to(169); push("rst_hold", gcyc, 4'hF, 8'hFF, 1'b0);
        reset_n = 1'b1;
        base = gcyc;
        push_phase("post_rst", 1, 8,      12'hEC0, 12'hD40, 12'hBC0, 12'hFFF);
        go_to(10);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            x = sb.pop_front();
            n_bad++;
            $display("FAIL %s: check for cycle %0d never performed", x.nm, x.e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
